uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- Serial transmitter that sends bytes out of a Tiny Tapeout user project on a single uio pin.
- Mirrors the byte-in path: it is the outbound end of the same 8N1 UART link the project parses on its input side.
- Bytes are accepted over a valid/ready handshake into a small FIFO, then serialized LSB-first.
- Sits inside the tt_um_ top level; its tx output drives uio_out[0] with uio_oe[0]=1.

Parameters:
- CLK_DIV, 104, clock cycles per bit (≥2); counter width $clog2(CLK_DIV).
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO can accept (= !full)
- tx  out  1  serial line, idle high
- busy  out  1  shifter active or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sampled on clk rising edge while rst=1):
  - tx=1, busy=0, tx_ready=1, fifo_count=0.
  - FSM goes to IDLE; FIFO pointers and bit counters clear.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge.
- Handshake:
  - A byte is pushed when tx_valid && tx_ready at a clk edge.
  - tx_ready is combinational !full.
  - tx_data need only be stable in the push cycle.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - Push while full is ignored (cannot happen with correct handshake).
  - Pop while empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop the head into shift register sreg, go to START; the bit timer loads CLK_DIV-1.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=sreg[0]; each bit lasts CLK_DIV cycles, then sreg shifts right. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then, if the FIFO is non-empty, pop and go straight to START (no idle gap); else go to IDLE.
- Latency: the first start-bit edge appears on tx one cycle after the push edge when idle and empty.
- Frame length is exactly 10*CLK_DIV cycles.
- Back-to-back frames are continuous.
- tx is registered (glitch-free).
- busy = (state != IDLE) || fifo_count != 0.
- All arithmetic is unsigned. The bit timer counts down and reloads at 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP.
  - tx = ^byte (even parity) for CLK_DIV cycles.
  - Frame becomes 11*CLK_DIV cycles.
- Undefined:
  - No PARITY state; 8N1 frames as above.
  - Parity logic and state encoding are absent from the netlist.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}, with PARITY always declared for encoding stability.
  - Constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
  - Function frame_cycles(div, parity).
- Sub-module byte_fifo (parameter DEPTH, WIDTH=8):
  - Ports clk, rst, push, din, pop, dout, full, empty, count.
  - Reusable by the receive side.

Test Plan:
- Reset behaviour: hold rst=1 for 5 cycles with tx_valid=1 -> tx=1, busy=0, fifo_count=0, and no frame emitted after release.
- Single byte, CLK_DIV=4: push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles. busy=1 throughout and falls 1 cycle after the stop bit ends.
- Burst: push 0x00,0xFF,0x55,0x3C,0x81 back-to-back.
  - tx_ready drops after 4 are queued (first already popped, so 5 accepted).
  - Frames are contiguous with no idle gap.
  - Decoded bytes match in order.
- Simultaneous push/pop: push exactly on the STOP->START pop cycle with count=1 -> count stays 1, no byte lost or duplicated.
- Mid-frame reset: assert rst during DATA bit 3 of 0x0F -> tx=1 next cycle and FIFO empty. Then pushing 0x42 sends a clean frame.
- UART_TX_PARITY_EN: send 0x07 -> parity bit 1 at cycle 9*CLK_DIV, frame length 11*CLK_DIV. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART byte path (transmit and receive sides).
// The PARITY state is always declared so state encodings stay fixed across builds.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  // Clock cycles in one complete frame: start + data + optional parity + stop.
  function automatic int unsigned frame_cycles(input int unsigned div, input logic parity);
    int unsigned bits;
    bits = UART_DATA_BITS + 2;
    if (parity) begin
      bits = bits + 1;
    end
    return div * bits;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular-buffer FIFO with combinational head output; shared by the UART transmit and receive
// paths. DEPTH must be a power of two so pointers wrap naturally.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO via valid/ready and are sent LSB-first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop bit.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 104,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);

  localparam logic [CntW-1:0] BitLast = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] LastBit = IdxW'(UART_DATA_BITS - 1);

  localparam logic [2:0] StIdle   = IDLE;
  localparam logic [2:0] StStart  = START;
  localparam logic [2:0] StData   = DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = PARITY;
`endif
  localparam logic [2:0] StStop   = STOP;

  logic [2:0]                state_q, state_d;
  logic [CntW-1:0]           timer_q, timer_d;
  logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] sreg_q, sreg_d;
  logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                      timer_last;
  logic                      fifo_pop;
  logic [7:0]                fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready   = !fifo_full;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (fifo_count != '0);
  assign timer_last = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    sreg_d    = sreg_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      StIdle: begin
        fifo_pop = !fifo_empty;
      end
      StStart: begin
        if (timer_last) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (timer_last) begin
          sreg_d    = sreg_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (timer_last) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (timer_last) begin
          // A queued byte starts immediately so consecutive frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StIdle) begin
      timer_d = timer_last ? BitLast : timer_q - 1'b1;
    end

    if (fifo_pop) begin
      state_d = StStart;
      sreg_d  = fifo_dout;
      timer_d = BitLast;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_dout;
`endif
    end
  end

  // Line level is derived from the next state so tx is a clean flop output.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = sreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      sreg_q    <= '0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      sreg_q    <= sreg_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed self-checking bench for uart_byte_tx at CLK_DIV=4, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN to check the parity bit and the longer frame.
module tb_uart_byte_tx;

  localparam int Div = 4;
`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int FL = Div * (10 + Par);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int   checks = 0;
  int   errors = 0;
  logic rec [0:511];

  uart_byte_tx #(
    .CLK_DIV    (Div),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at cycle k of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    int bp;
    bp = k / Div;
    if (bp == 0) return 1'b0;
    if (bp <= 8) return b[bp-1];
`ifdef UART_TX_PARITY_EN
    if (bp == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Decode a frame whose first start-bit cycle was recorded at rec[base].
  task automatic check_frame(input string tag, input int base, input logic [7:0] exp);
    logic [7:0] got;
    check_eq({tag, " start first"}, 32'(rec[base]), 32'd0);
    check_eq({tag, " start mid"}, 32'(rec[base+1]), 32'd0);
    for (int b = 0; b < 8; b++) begin
      got[b] = rec[base + Div*(b+1) + 1];
    end
    check_eq({tag, " data"}, 32'(got), 32'(exp));
`ifdef UART_TX_PARITY_EN
    check_eq({tag, " parity"}, 32'(rec[base + Div*9 + 1]), 32'(^exp));
`endif
    check_eq({tag, " stop mid"}, 32'(rec[base + FL - Div + 1]), 32'd1);
    check_eq({tag, " stop last"}, 32'(rec[base + FL - 1]), 32'd1);
  endtask

  initial begin
    logic [7:0] burst [5];
    int zeros;
    int bad_busy;
    burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'h3C; burst[4] = 8'h81;

    // Reset held with tx_valid asserted must not queue anything.
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hAB;
    repeat (5) step();
    check_eq("rst tx", 32'(tx), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst count", 32'(fifo_count), 32'd0);
    check_eq("rst ready", 32'(tx_ready), 32'd1);
    rst = 1'b0; tx_valid = 1'b0;
    zeros = 0;
    repeat (2*FL) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) zeros++;
    end
    check_eq("rst no frame", 32'(zeros), 32'd0);

    // Single byte 0xA5 with exact per-cycle line levels.
    tx_data = 8'hA5; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check_eq("single count after push", 32'(fifo_count), 32'd1);
    check_eq("single tx before start", 32'(tx), 32'd1);
    check_eq("single busy after push", 32'(busy), 32'd1);
    bad_busy = 0;
    for (int j = 1; j <= FL; j++) begin
      step();
      check_eq("single tx level", 32'(tx), 32'(exp_level(8'hA5, j-1)));
      if (busy !== 1'b1) bad_busy++;
    end
    check_eq("single busy during frame", 32'(bad_busy), 32'd0);
    step();
    check_eq("single busy after", 32'(busy), 32'd0);
    check_eq("single tx after", 32'(tx), 32'd1);

    // Burst of five; a sixth byte offered while full must be dropped.
    tx_data = burst[0]; tx_valid = 1'b1;
    for (int j = 0; j <= 5*FL; j++) begin
      step();
      rec[j] = tx;
      if (j == 3) begin
        check_eq("burst ready j3", 32'(tx_ready), 32'd1);
        check_eq("burst count j3", 32'(fifo_count), 32'd3);
      end
      if (j == 4) begin
        check_eq("burst ready full", 32'(tx_ready), 32'd0);
        check_eq("burst count full", 32'(fifo_count), 32'd4);
      end
      if (j == 5) check_eq("burst count ignored push", 32'(fifo_count), 32'd4);
      if (j < 4) tx_data = burst[j+1];
      else if (j == 4) tx_data = 8'h99;
      else tx_valid = 1'b0;
    end
    for (int f = 0; f < 5; f++) begin
      check_frame($sformatf("burst f%0d", f), 1 + f*FL, burst[f]);
    end
    step();
    check_eq("burst idle tx", 32'(tx), 32'd1);
    check_eq("burst idle busy", 32'(busy), 32'd0);
    check_eq("burst idle count", 32'(fifo_count), 32'd0);

    // Push coinciding with the STOP->START pop while one byte is queued.
    tx_data = 8'h12; tx_valid = 1'b1;
    for (int j = 0; j <= 3*FL; j++) begin
      step();
      rec[j] = tx;
      if (j == FL) check_eq("simul count before", 32'(fifo_count), 32'd1);
      if (j == FL + 1) check_eq("simul count same", 32'(fifo_count), 32'd1);
      tx_valid = (j == 1) || (j == FL);
      tx_data  = (j == 1) ? 8'h34 : 8'hC6;
    end
    check_frame("simul a", 1, 8'h12);
    check_frame("simul b", 1 + FL, 8'h34);
    check_frame("simul c", 1 + 2*FL, 8'hC6);
    step();
    check_eq("simul idle busy", 32'(busy), 32'd0);

    // Reset during data bit 3 of 0x0F with another byte queued.
    tx_data = 8'h0F; tx_valid = 1'b1;
    for (int j = 0; j <= 18; j++) begin
      step();
      if (j == 1) begin tx_data = 8'h99; tx_valid = 1'b1; end
      else tx_valid = 1'b0;
      if (j == 14) check_eq("midrst bit2", 32'(tx), 32'd1);
      if (j == 17) begin
        check_eq("midrst busy before", 32'(busy), 32'd1);
        check_eq("midrst count before", 32'(fifo_count), 32'd1);
        rst = 1'b1;
      end
    end
    check_eq("midrst tx", 32'(tx), 32'd1);
    check_eq("midrst count", 32'(fifo_count), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    zeros = 0;
    repeat (FL) begin
      step();
      if (tx !== 1'b1) zeros++;
    end
    check_eq("midrst no resume", 32'(zeros), 32'd0);
    tx_data = 8'h42; tx_valid = 1'b1;
    for (int j = 0; j <= FL; j++) begin
      step();
      rec[j] = tx;
      tx_valid = 1'b0;
    end
    check_frame("post rst", 1, 8'h42);
    step();
    check_eq("post rst idle", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity frames: odd-weight byte gives parity 1, even-weight gives 0.
    tx_data = 8'h07; tx_valid = 1'b1;
    for (int j = 0; j <= FL + 1; j++) begin
      step();
      rec[j] = tx;
      tx_valid = 1'b0;
      if (j == FL) check_eq("par07 busy last", 32'(busy), 32'd1);
      if (j == FL + 1) check_eq("par07 busy after", 32'(busy), 32'd0);
    end
    check_eq("par07 bit", 32'(rec[1 + 9*Div]), 32'd1);
    check_frame("par07", 1, 8'h07);
    tx_data = 8'h03; tx_valid = 1'b1;
    for (int j = 0; j <= FL + 1; j++) begin
      step();
      rec[j] = tx;
      tx_valid = 1'b0;
    end
    check_eq("par03 bit", 32'(rec[1 + 9*Div]), 32'd0);
    check_frame("par03", 1, 8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
